// File: rtl/spi_arb_pkg.sv
// Shared types for the SPI controller arbiter: FSM state encoding and
// a helper that sizes requester index fields.
package spi_arb_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    // A single requester still needs one bit to hold its index.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr,
// wrapping to the lowest set request below ptr.
module rr_pick
    import spi_arb_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int GW   = idx_width(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [GW-1:0]   ptr,
    output logic [GW-1:0]   grant,
    output logic            any
);

    logic          hi_any;
    logic          lo_any;
    logic [GW-1:0] hi_idx;
    logic [GW-1:0] lo_idx;

    // Scan downward so the last hit in each half is its lowest index.
    always_comb begin
        hi_any = 1'b0;
        lo_any = 1'b0;
        hi_idx = '0;
        lo_idx = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                if (GW'(i) >= ptr) begin
                    hi_any = 1'b1;
                    hi_idx = GW'(i);
                end else begin
                    lo_any = 1'b1;
                    lo_idx = GW'(i);
                end
            end
        end
        any   = hi_any | lo_any;
        grant = hi_any ? hi_idx : lo_idx;
    end

endmodule

// File: rtl/spi_arb.sv
// Round-robin arbiter sharing one SPI controller between NREQ bus requesters,
// with a timeout that completes a hung transfer with an error.
module spi_arb
    import spi_arb_pkg::*;
#(
    parameter int NREQ    = 2,
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_stb,
    input  logic [NREQ-1:0]   req_we,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ*DW-1:0] req_wdata,
    output logic [NREQ-1:0]   req_ack,
    output logic              req_err,
    output logic [DW-1:0]     req_rdata,
    output logic              spi_stb,
    output logic              spi_we,
    output logic [AW-1:0]     spi_addr,
    output logic [DW-1:0]     spi_wdata,
    input  logic              spi_ack,
    input  logic [DW-1:0]     spi_rdata
);

    localparam int GW = idx_width(NREQ);
    localparam int CW = $clog2(TIMEOUT) + 1;

    state_t         state;
    logic [GW-1:0]  ptr;
    logic [GW-1:0]  gnt;
    logic [CW-1:0]  cnt;

    logic [GW-1:0]  pick;
    logic           pick_any;
    logic           pick_we;
    logic [AW-1:0]  pick_addr;
    logic [DW-1:0]  pick_wdata;
    logic [NREQ-1:0] gnt_onehot;
    logic [GW-1:0]  next_ptr;
    logic           timeout_hit;

    rr_pick #(
        .NREQ (NREQ),
        .GW   (GW)
    ) u_pick (
        .req   (req_stb),
        .ptr   (ptr),
        .grant (pick),
        .any   (pick_any)
    );

    always_comb begin
        pick_we    = 1'b0;
        pick_addr  = '0;
        pick_wdata = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (pick == GW'(i)) begin
                pick_we    = req_we[i];
                pick_addr  = req_addr[i*AW +: AW];
                pick_wdata = req_wdata[i*DW +: DW];
            end
        end
    end

    assign gnt_onehot  = NREQ'(1) << gnt;
    assign next_ptr    = (gnt == GW'(NREQ - 1)) ? '0 : gnt + GW'(1);
    assign timeout_hit = (cnt == CW'(TIMEOUT - 1));

    // An ack arriving on the timeout cycle takes priority over the error.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= S_IDLE;
            ptr       <= '0;
            gnt       <= '0;
            cnt       <= '0;
            req_ack   <= '0;
            req_err   <= 1'b0;
            req_rdata <= '0;
            spi_stb   <= 1'b0;
            spi_we    <= 1'b0;
            spi_addr  <= '0;
            spi_wdata <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (pick_any) begin
                        gnt       <= pick;
                        spi_we    <= pick_we;
                        spi_addr  <= pick_addr;
                        spi_wdata <= pick_wdata;
                        spi_stb   <= 1'b1;
                        state     <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    spi_stb <= 1'b0;
                    cnt     <= '0;
                    state   <= S_WAIT;
                end
                S_WAIT: begin
                    if (spi_ack) begin
                        req_rdata <= spi_rdata;
                        req_err   <= 1'b0;
                        req_ack   <= gnt_onehot;
                        state     <= S_RESP;
                    end else if (timeout_hit) begin
                        req_rdata <= '0;
                        req_err   <= 1'b1;
                        req_ack   <= gnt_onehot;
                        state     <= S_RESP;
                    end else if (cnt != '1) begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_RESP: begin
                    req_ack <= '0;
                    ptr     <= next_ptr;
                    state   <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_arb.sv
// Self-checking bench for spi_arb: transaction-level reference model plus
// directed scenarios and a randomized traffic phase.
module tb_spi_arb;

    localparam int NREQ    = 2;
    localparam int AW      = 32;
    localparam int DW      = 32;
    localparam int TIMEOUT = 16;

    logic                clk = 1'b0;
    logic                rst = 1'b0;
    logic [NREQ-1:0]     req_stb = '0;
    logic [NREQ-1:0]     req_we = '0;
    logic [NREQ*AW-1:0]  req_addr = '0;
    logic [NREQ*DW-1:0]  req_wdata = '0;
    logic [NREQ-1:0]     req_ack;
    logic                req_err;
    logic [DW-1:0]       req_rdata;
    logic                spi_stb;
    logic                spi_we;
    logic [AW-1:0]       spi_addr;
    logic [DW-1:0]       spi_wdata;
    logic                spi_ack = 1'b0;
    logic [DW-1:0]       spi_rdata = '0;

    int vectors     = 0;
    int miscompares = 0;

    int          ack_mode  = -1;
    bit          fixed_en  = 1'b0;
    logic [DW-1:0] fixed_val = '0;
    int          stray_seq = 0;

    spi_arb #(
        .NREQ    (NREQ),
        .AW      (AW),
        .DW      (DW),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_stb   (req_stb),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_ack   (req_ack),
        .req_err   (req_err),
        .req_rdata (req_rdata),
        .spi_stb   (spi_stb),
        .spi_we    (spi_we),
        .spi_addr  (spi_addr),
        .spi_wdata (spi_wdata),
        .spi_ack   (spi_ack),
        .spi_rdata (spi_rdata)
    );

    always #5 clk = ~clk;

    // Reference model: tracks one transfer by its age in cycles since grant.
    logic [NREQ-1:0] e_ack = '0;
    logic            e_err = 1'b0;
    logic [DW-1:0]   e_rdata = '0;
    logic            e_stb = 1'b0;
    logic            e_we = 1'b0;
    logic [AW-1:0]   e_addr = '0;
    logic [DW-1:0]   e_wdata = '0;
    int m_ptr = 0, m_g = 0, m_age = 0, m_win = -1;
    bit m_busy = 1'b0, m_done = 1'b0;

    always @(posedge clk) begin
        if (!rst) begin
            e_ack = '0; e_err = 1'b0; e_rdata = '0;
            e_stb = 1'b0; e_we = 1'b0; e_addr = '0; e_wdata = '0;
            m_ptr = 0; m_busy = 1'b0; m_done = 1'b0;
        end else if (!m_busy) begin
            e_ack = '0;
            e_stb = 1'b0;
            m_win = -1;
            for (int k = 0; k < NREQ; k++) begin
                if (m_win < 0 && req_stb[(m_ptr + k) % NREQ]) m_win = (m_ptr + k) % NREQ;
            end
            if (m_win >= 0) begin
                m_busy  = 1'b1;
                m_done  = 1'b0;
                m_g     = m_win;
                m_age   = 0;
                e_stb   = 1'b1;
                e_we    = req_we[m_win];
                e_addr  = req_addr[m_win*AW +: AW];
                e_wdata = req_wdata[m_win*DW +: DW];
            end
        end else if (m_done) begin
            e_ack  = '0;
            m_ptr  = (m_g + 1) % NREQ;
            m_busy = 1'b0;
        end else begin
            e_stb = 1'b0;
            m_age++;
            if (m_age >= 2) begin
                if (spi_ack) begin
                    m_done = 1'b1; e_rdata = spi_rdata; e_err = 1'b0; e_ack = NREQ'(1) << m_g;
                end else if (m_age - 1 == TIMEOUT) begin
                    m_done = 1'b1; e_rdata = '0; e_err = 1'b1; e_ack = NREQ'(1) << m_g;
                end
            end
        end
    end

    // Bench-side SPI controller: answers each strobe after a configurable delay.
    int cd = -1;
    int stray_seen = 0;
    int dly = 0;

    task automatic fireAck();
        spi_ack   = 1'b1;
        spi_rdata = fixed_en ? fixed_val : DW'($urandom);
        cd = -1;
    endtask

    always @(negedge clk) begin
        spi_ack = 1'b0;
        if (!rst) begin
            cd = -1;
        end else begin
            if (cd > 0) begin
                cd--;
                if (cd == 0) fireAck();
            end
            if (spi_stb) begin
                dly = (ack_mode == -2) ? int'($urandom_range(0, TIMEOUT + 4)) : ack_mode;
                if (dly == 0) fireAck();
                else cd = (dly > 0) ? dly : -1;
            end else if (stray_seq != stray_seen) begin
                stray_seen = stray_seq;
                fireAck();
            end else if (ack_mode == -2 && cd < 0 && $urandom_range(0, 15) == 0) begin
                fireAck();
            end
        end
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic reportExpired(input string name);
        vectors++;
        miscompares++;
        $display("[TB] FAIL %s: wait budget expired at %0t", name, $time);
    endtask

    // One cycle: compare every output against the model, retire acked requests.
    task automatic step();
        @(negedge clk);
        checkOutput("req_ack",   64'(req_ack),   64'(e_ack));
        checkOutput("req_err",   64'(req_err),   64'(e_err));
        checkOutput("req_rdata", 64'(req_rdata), 64'(e_rdata));
        checkOutput("spi_stb",   64'(spi_stb),   64'(e_stb));
        checkOutput("spi_we",    64'(spi_we),    64'(e_we));
        checkOutput("spi_addr",  64'(spi_addr),  64'(e_addr));
        checkOutput("spi_wdata", 64'(spi_wdata), 64'(e_wdata));
        for (int k = 0; k < NREQ; k++) begin
            if (req_ack[k]) req_stb[k] = 1'b0;
        end
    endtask

    task automatic applyStimulus(input int k, input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
        req_stb[k]                = 1'b1;
        req_we[k]                 = we;
        req_addr[k*AW +: AW]      = addr;
        req_wdata[k*DW +: DW]     = wdata;
    endtask

    task automatic waitAck(input int budget, output int cycles);
        cycles = 0;
        while (cycles < budget) begin
            step();
            cycles++;
            if (req_ack != '0) break;
        end
        if (req_ack == '0) reportExpired("wait_req_ack");
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (n < budget && (m_busy || req_stb != '0)) begin
            step();
            n++;
        end
        if (m_busy || req_stb != '0) reportExpired("drain");
    endtask

    task automatic doReset();
        rst = 1'b0;
        req_stb = '0;
        step();
        step();
        rst = 1'b1;
    endtask

    logic [AW-1:0]   addr_seq[$];
    logic [NREQ-1:0] ack_seq[$];
    logic [AW-1:0]   exp_addr[4] = '{32'h100, 32'h200, 32'h100, 32'h200};
    logic [NREQ-1:0] exp_ack[4]  = '{2'b01, 2'b10, 2'b01, 2'b10};

    initial begin
        int cyc;
        int acks;
        int n;

        step();
        step();
        checkOutput("rst_req_ack",   64'(req_ack),   64'h0);
        checkOutput("rst_spi_stb",   64'(spi_stb),   64'h0);
        checkOutput("rst_spi_addr",  64'(spi_addr),  64'h0);
        checkOutput("rst_req_rdata", 64'(req_rdata), 64'h0);
        rst = 1'b1;

        $display("[TB] single read");
        ack_mode = 5; fixed_en = 1'b1; fixed_val = 32'hDEADBEEF;
        applyStimulus(0, 1'b0, 32'h80000400, 32'h0);
        step();
        checkOutput("rd_stb",  64'(spi_stb),  64'h1);
        checkOutput("rd_addr", 64'(spi_addr), 64'h80000400);
        checkOutput("rd_we",   64'(spi_we),   64'h0);
        waitAck(40, cyc);
        checkOutput("rd_latency", 64'(cyc),       64'd6);
        checkOutput("rd_ack",     64'(req_ack),   64'b01);
        checkOutput("rd_rdata",   64'(req_rdata), 64'hDEADBEEF);
        checkOutput("rd_err",     64'(req_err),   64'h0);
        drain(50);

        $display("[TB] contention");
        doReset();
        ack_mode = 4; fixed_en = 1'b0;
        applyStimulus(0, 1'b0, 32'h100, 32'h0);
        applyStimulus(1, 1'b0, 32'h200, 32'h0);
        acks = 0; n = 0;
        while (acks < 4 && n < 200) begin
            step();
            n++;
            if (spi_stb) addr_seq.push_back(spi_addr);
            if (req_ack != '0) begin
                ack_seq.push_back(req_ack);
                acks++;
                if (acks <= 2) begin
                    if (req_ack[0]) applyStimulus(0, 1'b0, 32'h100, 32'h0);
                    else            applyStimulus(1, 1'b0, 32'h200, 32'h0);
                end
            end
        end
        checkOutput("cont_stb_count", 64'(addr_seq.size()), 64'd4);
        checkOutput("cont_ack_count", 64'(ack_seq.size()),  64'd4);
        for (int i = 0; i < 4 && i < addr_seq.size(); i++) checkOutput("cont_addr", 64'(addr_seq[i]), 64'(exp_addr[i]));
        for (int i = 0; i < 4 && i < ack_seq.size(); i++)  checkOutput("cont_ack",  64'(ack_seq[i]),  64'(exp_ack[i]));
        drain(50);

        $display("[TB] write");
        ack_mode = 3;
        applyStimulus(1, 1'b1, 32'h80000404, 32'h12345678);
        step();
        checkOutput("wr_stb",   64'(spi_stb),   64'h1);
        checkOutput("wr_we",    64'(spi_we),    64'h1);
        checkOutput("wr_wdata", 64'(spi_wdata), 64'h12345678);
        checkOutput("wr_addr",  64'(spi_addr),  64'h80000404);
        waitAck(40, cyc);
        checkOutput("wr_ack", 64'(req_ack), 64'b10);
        checkOutput("wr_err", 64'(req_err), 64'h0);
        drain(50);

        $display("[TB] timeout");
        ack_mode = -1;
        applyStimulus(0, 1'b0, 32'h300, 32'h0);
        step();
        waitAck(60, cyc);
        checkOutput("to_latency", 64'(cyc),       64'(TIMEOUT + 1));
        checkOutput("to_ack",     64'(req_ack),   64'b01);
        checkOutput("to_err",     64'(req_err),   64'h1);
        checkOutput("to_rdata",   64'(req_rdata), 64'h0);
        drain(50);
        ack_mode = 2; fixed_en = 1'b1; fixed_val = 32'h55AA55AA;
        applyStimulus(1, 1'b0, 32'h304, 32'h0);
        waitAck(40, cyc);
        checkOutput("after_to_ack",   64'(req_ack),   64'b10);
        checkOutput("after_to_err",   64'(req_err),   64'h0);
        checkOutput("after_to_rdata", 64'(req_rdata), 64'h55AA55AA);
        drain(50);

        $display("[TB] reset during wait");
        applyStimulus(0, 1'b0, 32'h100, 32'h0);
        waitAck(40, cyc);
        drain(50);
        ack_mode = -1;
        applyStimulus(0, 1'b0, 32'h100, 32'h0);
        repeat (4) step();
        rst = 1'b0;
        req_stb = '0;
        step();
        checkOutput("mid_rst_ack",   64'(req_ack),   64'h0);
        checkOutput("mid_rst_stb",   64'(spi_stb),   64'h0);
        checkOutput("mid_rst_addr",  64'(spi_addr),  64'h0);
        checkOutput("mid_rst_rdata", 64'(req_rdata), 64'h0);
        checkOutput("mid_rst_err",   64'(req_err),   64'h0);
        rst = 1'b1;
        repeat (4) begin
            step();
            checkOutput("mid_rst_no_ack", 64'(req_ack), 64'h0);
        end
        ack_mode = 2;
        applyStimulus(0, 1'b0, 32'h100, 32'h0);
        applyStimulus(1, 1'b0, 32'h200, 32'h0);
        step();
        checkOutput("post_rst_stb",   64'(spi_stb),  64'h1);
        checkOutput("post_rst_grant", 64'(spi_addr), 64'h100);
        drain(80);

        $display("[TB] stray and coincident ack");
        stray_seq++;
        repeat (3) begin
            step();
            checkOutput("stray_no_ack", 64'(req_ack), 64'h0);
        end
        ack_mode = TIMEOUT; fixed_val = 32'hCAFEF00D;
        applyStimulus(1, 1'b0, 32'h400, 32'h0);
        step();
        waitAck(60, cyc);
        checkOutput("coin_latency", 64'(cyc),       64'(TIMEOUT + 1));
        checkOutput("coin_ack",     64'(req_ack),   64'b10);
        checkOutput("coin_err",     64'(req_err),   64'h0);
        checkOutput("coin_rdata",   64'(req_rdata), 64'hCAFEF00D);
        drain(50);
        ack_mode = TIMEOUT + 1;
        applyStimulus(0, 1'b0, 32'h404, 32'h0);
        step();
        waitAck(60, cyc);
        checkOutput("late_err",   64'(req_err),   64'h1);
        checkOutput("late_rdata", 64'(req_rdata), 64'h0);
        repeat (4) step();
        drain(50);

        $display("[TB] random traffic");
        ack_mode = -2; fixed_en = 1'b0;
        for (int c = 0; c < 2000; c++) begin
            step();
            for (int k = 0; k < NREQ; k++) begin
                if (!req_stb[k]) begin
                    if ($urandom_range(0, 3) == 0)
                        applyStimulus(k, 1'($urandom_range(0, 1)), $urandom, $urandom);
                end else if (m_busy && m_g == k) begin
                    if ($urandom_range(0, 7) == 0) req_stb[k] = 1'b0;
                    else if ($urandom_range(0, 5) == 0) req_addr[k*AW +: AW] = $urandom;
                end
            end
        end
        drain(200);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/spi_arb.md
Name: spi_arb

Overview:
- Shares the single SPI flash/peripheral controller between NREQ bus requesters, e.g. instruction fetch and data load/store.
- Uses round-robin arbitration.
- Drives the controller's strobe/write/address handshake.
- Returns the response to the granted requester only.
- Sits between the core bus ports and the SPI controller.
- Guards against a hung transfer with a timeout that completes the request with an error.

Parameters:
- NREQ, 2, number of requesters (2..8).
- AW, 32, address width.
- DW, 32, data width.
- TIMEOUT, 1024, max cycles waiting for spi_ack before error completion.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-low reset.
- req_stb  in  NREQ  per-requester request; level, held until that requester's ack.
- req_we  in  NREQ  per-requester write enable.
- req_addr  in  NREQ*AW  packed addresses; requester k at [k*AW +: AW].
- req_wdata  in  NREQ*DW  packed write data.
- req_ack  out  NREQ  one-cycle completion pulse, at most one bit set.
- req_err  out  1  valid with req_ack; 1 = timeout.
- req_rdata  out  DW  read data, valid with req_ack.
- spi_stb  out  1  one-cycle strobe to the SPI controller.
- spi_we  out  1  write enable to the controller.
- spi_addr  out  AW  address to the controller.
- spi_wdata  out  DW  write data to the controller.
- spi_ack  in  1  controller completion pulse.
- spi_rdata  in  DW  controller read data, valid with spi_ack.

Behaviour:
- Reset (rst==0 at edge):
  - state=IDLE, rr pointer=0, timeout counter=0.
  - req_ack=0, req_err=0, req_rdata=0.
  - spi_stb=0, spi_we=0, spi_addr=0, spi_wdata=0.
  - Reset mid-transfer abandons it silently: no ack is issued. The controller shares rst.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any req_stb bit is set, pick the winner g by round-robin: first set bit at or after pointer, scanning upward with wrap-around.
  - Latch g, we, addr and wdata into the spi_* registers, then go to ISSUE.
  - Otherwise stay in IDLE.
- ISSUE:
  - spi_stb=1 for exactly this cycle.
  - Clear the timeout counter, then go to WAIT.
- WAIT:
  - spi_stb=0. spi_addr, spi_we and spi_wdata hold their latched values.
  - On spi_ack: latch spi_rdata into req_rdata, clear req_err, go to RESP.
  - If the counter reaches TIMEOUT-1 without spi_ack: req_rdata=0, req_err=1, go to RESP.
  - spi_ack in the same cycle as the timeout: ack wins and err=0.
- RESP:
  - req_ack[g]=1 for one cycle.
  - pointer = (g+1) mod NREQ, then go to IDLE.
- Latency:
  - A request seen in IDLE at cycle N produces spi_stb at N+1.
  - spi_ack at cycle M produces req_ack at M+1.
  - The next grant is evaluated at M+2. Minimum 3 idle-overhead cycles per transfer.
- spi_ack outside WAIT is ignored; no state change.
- Requester contract:
  - req_stb is held while pending.
  - A requester dropping stb after grant does not cancel the transfer; the ack is still pulsed.
  - req_stb sampled in IDLE only; address changes after the grant are not seen.
- Fairness: with all NREQ requesting continuously, grants rotate 0,1,..,NREQ-1,0. No requester waits more than NREQ-1 transfers.
- Timeout counter: width clog2(TIMEOUT)+1; saturates and cannot wrap.
- req_rdata holds its value until the next RESP.

Decomposition:
- Package spi_arb_pkg:
  - state encoding localparams S_IDLE=0, S_ISSUE=1, S_WAIT=2, S_RESP=3.
  - clog2-based width constant for the grant index.
- One sub-module: rr_pick.
  - Combinational round-robin picker: inputs req[NREQ] and ptr; outputs grant index and any.
  - Reusable for later bus arbiters.
- FSM, latching and timeout stay in spi_arb.

Test Plan:
- Reset, then single read: req_stb=01, addr0=0x80000400.
  - spi_stb pulses 1 cycle later with spi_addr=0x80000400, spi_we=0.
  - Return spi_ack with spi_rdata=0xDEADBEEF 5 cycles later.
  - Expect req_ack=01 next cycle, req_rdata=0xDEADBEEF, req_err=0.
- Contention: req_stb=11 held, addr0=0x100, addr1=0x200, controller acks after 4 cycles each.
  - spi_addr sequence 0x100,0x200,0x100,0x200.
  - req_ack alternates 01,10,01,10.
- Write: req1 we=1, addr=0x80000404, wdata=0x12345678.
  - spi_we=1 and spi_wdata=0x12345678 at strobe.
  - req_ack=10, err=0.
- Timeout, TIMEOUT=16: never assert spi_ack.
  - req_ack pulses with req_err=1 and req_rdata=0 at the 16th WAIT cycle+1.
  - FSM returns to IDLE; the next request is serviced normally.
- Reset mid-WAIT: drop rst for 1 cycle during WAIT.
  - No req_ack; all outputs 0; pointer 0.
  - A following req_stb=11 grants requester 0 first.
- Stray spi_ack in IDLE, and spi_ack coincident with the timeout cycle:
  - Stray ack gives no req_ack.
  - Coincident case completes with err=0 and the ack's rdata.
